// File: rtl/kanagawa_delay_pkg.sv
// Shared definitions for the fixed-latency delay line: implementation
// selection, address-width helper and the LUTRAM crossover point.
package kanagawa_delay_pkg;

  // Below this delay a flop chain is smaller and faster than a memory.
  localparam int LUTRAM_MIN_DELAY = 3;

  // Which structure a given parameter set elaborates into.
  typedef enum logic [1:0] {
    IMPL_WIRE      = 2'd0,
    IMPL_CHAIN     = 2'd1,
    IMPL_CHAIN_DSP = 2'd2,
    IMPL_LUTRAM    = 2'd3
  } impl_e;

  // clog2 that never returns 0, so a one-entry memory still has an address bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Map the configuration parameters onto one implementation choice.
  function automatic impl_e select_impl(input int delay, input int use_lutram,
                                        input int use_dsp);
    if (delay == 0)                                        return IMPL_WIRE;
    else if (use_lutram != 0 && delay >= LUTRAM_MIN_DELAY) return IMPL_LUTRAM;
    else if (use_dsp != 0)                                 return IMPL_CHAIN_DSP;
    else                                                   return IMPL_CHAIN;
  endfunction

endpackage

// File: rtl/kanagawa_delay_ram.sv
// Simple dual-port WIDTH x DEPTH distributed memory: synchronous write,
// asynchronous read. A read of the address being written in the same cycle
// returns the old word (read-before-write), which the circular buffer relies on.
// Contents are never reset.
module kanagawa_delay_ram
  import kanagawa_delay_pkg::*;
#(
  parameter int    WIDTH         = 16,
  parameter int    DEPTH         = 7,
  parameter int    AW            = clog2_min1(DEPTH),
  parameter string DEVICE_FAMILY = "Stratix10"
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  localparam bit IS_INTEL = (DEVICE_FAMILY == "Stratix10") ||
                            (DEVICE_FAMILY == "Agilex")    ||
                            (DEVICE_FAMILY == "Arria10")   ||
                            (DEVICE_FAMILY == "Cyclone10GX");

  if (IS_INTEL) begin : g_mlab
    (* ramstyle = "MLAB, no_rw_check" *)
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port: one word per enabled clock.
    always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[i_rd_addr];
  end else begin : g_dist
    (* ram_style = "distributed" *)
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port: one word per enabled clock.
    always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[i_rd_addr];
  end

endmodule

// File: rtl/kanagawa_fixed_delay_fifo.sv
// Free-running fixed-latency delay line. Every clock data_in is captured and
// reappears on data_out DELAY cycles later. Short delays use a flop chain,
// long delays a circular buffer in distributed RAM followed by an output flop
// (DEPTH = DELAY-1 memory slots plus that flop give DELAY stages).
module kanagawa_fixed_delay_fifo
  import kanagawa_delay_pkg::*;
#(
  parameter int    WIDTH         = 16,
  parameter int    DELAY         = 8,
  parameter int    USE_LUTRAM    = 1,
  parameter string DEVICE_FAMILY = "Stratix10",
  parameter int    USE_DSP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  localparam impl_e IMPL = select_impl(DELAY, USE_LUTRAM, USE_DSP);

  if (IMPL == IMPL_WIRE) begin : g_wire
    // Zero delay: no state, clock and reset are intentionally unused.
    logic w_unused;
    assign w_unused = clk ^ rst;
    assign data_out = data_in;

  end else if (IMPL == IMPL_LUTRAM) begin : g_lutram
    localparam int DEPTH = DELAY - 1;
    localparam int AW    = clog2_min1(DEPTH);

    logic [AW-1:0]    r_ptr;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_rd_data;

    // Single pointer serves both ports; it wraps at DEPTH-1, not at 2**AW.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                          r_ptr <= '0;
      else if (r_ptr == AW'(DEPTH - 1))  r_ptr <= '0;
      else                               r_ptr <= r_ptr + 1'b1;
    end

    // Writes are blocked while in reset so data_in is ignored there.
    kanagawa_delay_ram #(
      .WIDTH         (WIDTH),
      .DEPTH         (DEPTH),
      .AW            (AW),
      .DEVICE_FAMILY (DEVICE_FAMILY)
    ) u_ram (
      .clk       (clk),
      .i_wr_en   (rst),
      .i_wr_addr (r_ptr),
      .i_wr_data (data_in),
      .i_rd_addr (r_ptr),
      .o_rd_data (w_rd_data)
    );

    // Output register: the word written DEPTH cycles ago, read before overwrite.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_out <= '0;
      else      r_out <= w_rd_data;
    end

    assign data_out = r_out;

  end else if (IMPL == IMPL_CHAIN_DSP) begin : g_chain_dsp
    (* use_dsp = "yes", altera_attribute = "-name AUTO_SHIFT_REGISTER_RECOGNITION OFF" *)
    logic [WIDTH-1:0] r_stage [DELAY];

    // Shift chain, stage 0 captures data_in; all stages clear on reset.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int k = 0; k < DELAY; k++) r_stage[k] <= '0;
      end else begin
        r_stage[0] <= data_in;
        for (int k = 1; k < DELAY; k++) r_stage[k] <= r_stage[k-1];
      end
    end

    assign data_out = r_stage[DELAY-1];

  end else begin : g_chain
    logic [WIDTH-1:0] r_stage [DELAY];

    // Shift chain, stage 0 captures data_in; all stages clear on reset.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int k = 0; k < DELAY; k++) r_stage[k] <= '0;
      end else begin
        r_stage[0] <= data_in;
        for (int k = 1; k < DELAY; k++) r_stage[k] <= r_stage[k-1];
      end
    end

    assign data_out = r_stage[DELAY-1];
  end

endmodule

// File: tb/tb_kanagawa_fixed_delay_fifo.sv
// Bench for the delay line: twelve configurations share one clock, reset and
// stimulus stream. Each driven word is pushed into a per-instance expected
// queue; a negedge monitor pops one entry per instance per cycle and compares.
module tb_kanagawa_fixed_delay_fifo;

  localparam int N = 12;
  localparam int DLY [N] = '{8, 8, 8, 0, 1, 2, 3, 7, 16, 7, 5, 5};
  localparam int LUT [N] = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 0, 1, 0};
  localparam int DSP [N] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  localparam int WID [N] = '{16, 16, 16, 16, 16, 16, 16, 16, 16, 16, 64, 64};

  typedef struct packed {
    logic        chk;
    logic [63:0] val;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [15:0] d16;
  logic [63:0] d64;
  logic [63:0] dout [N];
  bit          in_reset;

  exp_t exp_q [N][$];
  int   checks;
  int   failures;

  // ---------------- DUT instances ----------------
  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W = WID[g];
    logic [W-1:0] din;
    logic [W-1:0] dq;
    if (W == 64) begin : g_w
      assign din = d64;
    end else begin : g_n
      assign din = d16;
    end
    kanagawa_fixed_delay_fifo #(
      .WIDTH         (W),
      .DELAY         (DLY[g]),
      .USE_LUTRAM    (LUT[g]),
      .DEVICE_FAMILY ("Stratix10"),
      .USE_DSP       (DSP[g])
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .data_in  (din),
      .data_out (dq)
    );
    assign dout[g] = 64'(dq);
  end

  // Memory-backed instances hold stale words for DELAY cycles after reset.
  function automatic bit is_ram(input int k);
    return (LUT[k] != 0) && (DLY[k] > 2);
  endfunction

  task automatic check(input int k, input string name,
                       input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s dut=%0d delay=%0d got=%h exp=%h t=%0t",
               name, k, DLY[k], act, exp_v, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one word for one cycle; outside reset it is expected back DELAY later.
  task automatic drive(input logic [15:0] w16, input logic [63:0] w64);
    exp_t e;
    d16 = w16;
    d64 = w64;
    if (!in_reset) begin
      for (int k = 0; k < N; k++) begin
        e.chk = 1'b1;
        e.val = (WID[k] == 64) ? w64 : {48'h0, w16};
        exp_q[k].push_back(e);
      end
    end
    step();
  endtask

  task automatic drive_rand();
    drive(16'($urandom_range(0, 65535)), {$urandom(), $urandom()});
  endtask

  // Deassert reset; the first DELAY outputs are zero (chain) or unknown (RAM).
  task automatic release_reset();
    exp_t e;
    rst      = 1'b1;
    in_reset = 1'b0;
    for (int k = 0; k < N; k++) begin
      exp_q[k].delete();
      for (int j = 0; j < DLY[k]; j++) begin
        e.chk = !is_ram(k);
        e.val = 64'h0;
        exp_q[k].push_back(e);
      end
    end
  endtask

  // Assert reset between edges and confirm the outputs clear without a clock.
  task automatic async_reset();
    #2;
    rst      = 1'b0;
    in_reset = 1'b1;
    for (int k = 0; k < N; k++) exp_q[k].delete();
    #1;
    for (int k = 0; k < N; k++) begin
      if (DLY[k] != 0) check(k, "async_clear", dout[k], 64'h0);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < N; k++) begin
      if (in_reset) begin
        if (DLY[k] == 0) check(k, "rst_comb", dout[k], {48'h0, d16});
        else             check(k, "rst_zero", dout[k], 64'h0);
      end else if (exp_q[k].size() == 0) begin
        checks++;
        failures++;
        $display("FAIL underflow dut=%0d got=%h exp=<none> t=%0t", k, dout[k], $time);
      end else begin
        e = exp_q[k].pop_front();
        if (e.chk) check(k, "data", dout[k], e.val);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    in_reset = 1'b1;
    d16      = 16'h0;
    d64      = 64'h0;

    // Power-on reset, 10 cycles with junk on data_in.
    repeat (10) drive_rand();
    release_reset();

    // Ramp, interrupted by an asynchronous reset at word 500.
    for (int i = 0; i < 600; i++) begin
      if (i == 500) begin
        async_reset();
        step();
        repeat (4) drive_rand();
        release_reset();
        break;
      end
      drive(16'(i), {$urandom(), $urandom()});
    end

    // Ramp restarts from zero after release; pre-reset words must not return.
    for (int i = 0; i < 1024; i++) drive(16'(i), {$urandom(), $urandom()});

    // Reset again; all-ones word right after release, then random data.
    rst      = 1'b0;
    in_reset = 1'b1;
    repeat (5) drive_rand();
    release_reset();
    drive(16'hFFFF, {2{32'hFFFF_FFFF}});
    repeat (500) drive_rand();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
